// File: rtl/pcm_pkg.sv
// Shared PCM definitions: serial frame format encodings and the parameter
// legality checks used by the audio serialisers.
package pcm_pkg;

  // Frame format selector; the reserved code falls back to I2S.
  typedef enum logic [1:0] {
    FMT_I2S  = 2'b00,
    FMT_LJ   = 2'b01,
    FMT_RJ   = 2'b10,
    FMT_RSVD = 2'b11
  } fmt_e;

  // Sample width must fit the supported 8..32 bit range.
  function automatic bit data_w_ok(input int data_w);
    return (data_w >= 8) && (data_w <= 32);
  endfunction

  // A slot needs one spare bck so the I2S one-bit delay still fits.
  function automatic bit slot_w_ok(input int data_w, input int slot_w);
    return slot_w >= data_w + 1;
  endfunction

  // bck is a 50% duty clock derived from scki, so the divider must be even.
  function automatic bit bck_div_ok(input int bck_div);
    return (bck_div >= 2) && ((bck_div % 2) == 0);
  endfunction

endpackage

// File: rtl/shift_register.sv
// Parallel-load, MSB-first shift register. The MSB is presented directly
// from the register so the serial output is glitch-free.
module shift_register
  import pcm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] shifted;

  genvar gi;
  generate
    // Each bit takes its lower neighbour on a shift; bit 0 fills with zero.
    for (gi = 0; gi < WIDTH; gi++) begin : g_shift
      if (gi == 0) begin : g_lsb
        assign shifted[gi] = 1'b0;
      end else begin : g_bit
        assign shifted[gi] = q_reg[gi-1];
      end
    end
  endgenerate

  // Load takes priority over shift; cleared while rst is low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q_reg <= '0;
    end else if (load) begin
      q_reg <= din;
    end else if (shift) begin
      q_reg <= shifted;
    end
  end

  assign msb = q_reg[WIDTH-1];

endmodule

// File: rtl/i2s_tx.sv
// I2S / left-justified / right-justified stereo transmitter. A one-deep
// holding register accepts sample pairs; each frame start moves the held
// pair into the active slot words, which are serialised MSB first.
module i2s_tx
  import pcm_pkg::*;
#(
  parameter int DATA_W  = 24,
  parameter int SLOT_W  = 32,
  parameter int BCK_DIV = 4
) (
  input  logic              scki,
  input  logic              rst,
  input  logic [1:0]        fmt,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_left,
  input  logic [DATA_W-1:0] s_right,
  output logic              bck,
  output logic              lrck,
  output logic              adata,
  output logic              underrun
);

  localparam int DIV_W     = $clog2(BCK_DIV);
  localparam int BIT_W     = $clog2(2 * SLOT_W);
  localparam int LJ_SHIFT  = SLOT_W - DATA_W;
  localparam int I2S_SHIFT = SLOT_W - DATA_W - 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCK_DIV / 2);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(2 * SLOT_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] RIGHT_K0 = BIT_W'(SLOT_W);

  // Reject illegal geometry at elaboration rather than producing a
  // silently broken frame.
  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("i2s_tx: DATA_W must be in 8..32");
  end
  if (!slot_w_ok(DATA_W, SLOT_W)) begin : g_bad_slot_w
    $error("i2s_tx: SLOT_W must be at least DATA_W+1");
  end
  if (!bck_div_ok(BCK_DIV)) begin : g_bad_bck_div
    $error("i2s_tx: BCK_DIV must be even and at least 2");
  end

  // Place a sample inside its slot so the shifter only ever shifts out MSB
  // first: LJ starts at the slot MSB, I2S one bit later, RJ ends at the LSB.
  function automatic logic [SLOT_W-1:0] align_word(input logic [DATA_W-1:0] word,
                                                   input logic [1:0]        f);
    logic [SLOT_W-1:0] ext;
    ext = {{(SLOT_W - DATA_W){1'b0}}, word};
    case (f)
      FMT_LJ:  align_word = ext << LJ_SHIFT;
      FMT_RJ:  align_word = ext;
      default: align_word = ext << I2S_SHIFT;
    endcase
  endfunction

  // run_reg delays the divider by the release edge; primed_reg marks that
  // the first frame has begun, so the first wrap is itself a frame start.
  logic              run_reg;
  logic              primed_reg;
  logic [DIV_W-1:0]  div_reg;
  logic [DIV_W-1:0]  div_next;
  logic [BIT_W-1:0]  bit_reg;
  logic [BIT_W-1:0]  bit_next;
  logic              hold_valid_reg;
  logic [DATA_W-1:0] hold_left_reg;
  logic [DATA_W-1:0] hold_right_reg;
  logic [DATA_W-1:0] active_right_reg;
  logic [1:0]        fmt_reg;
  logic              bck_reg;
  logic              lrck_reg;
  logic              underrun_reg;

  logic              wrap;
  logic              frame_start;
  logic              right_start;
  logic              transfer;
  logic              sr_load;
  logic              sr_shift;
  logic [SLOT_W-1:0] sr_din;

  assign s_ready  = ~hold_valid_reg;
  assign transfer = s_valid & ~hold_valid_reg;

  // Divider, bit counter and slot-boundary decode.
  always_comb begin
    wrap        = 1'b0;
    frame_start = 1'b0;
    right_start = 1'b0;
    div_next    = div_reg;
    bit_next    = bit_reg;
    sr_load     = 1'b0;
    sr_shift    = 1'b0;
    sr_din      = '0;
    if (run_reg) begin
      if (div_reg == DIV_LAST) begin
        wrap     = 1'b1;
        div_next = '0;
      end else begin
        div_next = div_reg + DIV_ONE;
      end
    end
    if (wrap) begin
      if (!primed_reg || (bit_reg == BIT_LAST)) begin
        bit_next    = '0;
        frame_start = 1'b1;
      end else begin
        bit_next = bit_reg + BIT_ONE;
      end
      right_start = (bit_next == RIGHT_K0);
    end
    // Left word comes straight from the holding register with the fmt
    // being latched this edge; the right word uses the latched copies.
    if (frame_start) begin
      sr_load = 1'b1;
      sr_din  = align_word(hold_valid_reg ? hold_left_reg : '0, fmt);
    end else if (right_start) begin
      sr_load = 1'b1;
      sr_din  = align_word(active_right_reg, fmt_reg);
    end else begin
      sr_shift = wrap;
    end
  end

  // Timing counters and registered clock / word-select outputs.
  always_ff @(posedge scki) begin
    if (!rst) begin
      run_reg    <= 1'b0;
      primed_reg <= 1'b0;
      div_reg    <= '0;
      bit_reg    <= '0;
      bck_reg    <= 1'b0;
      lrck_reg   <= 1'b1;
    end else begin
      run_reg    <= 1'b1;
      primed_reg <= primed_reg | wrap;
      div_reg    <= div_next;
      bit_reg    <= bit_next;
      bck_reg    <= (div_next >= DIV_HALF);
      if (wrap) begin
        lrck_reg <= (bit_next >= RIGHT_K0);
      end
    end
  end

  // Holding register, frame-start handover and underrun detection.
  always_ff @(posedge scki) begin
    if (!rst) begin
      hold_valid_reg   <= 1'b0;
      hold_left_reg    <= '0;
      hold_right_reg   <= '0;
      active_right_reg <= '0;
      fmt_reg          <= FMT_I2S;
      underrun_reg     <= 1'b0;
    end else begin
      underrun_reg <= frame_start & ~hold_valid_reg;
      if (frame_start) begin
        active_right_reg <= hold_valid_reg ? hold_right_reg : '0;
        fmt_reg          <= fmt;
      end
      if (transfer) begin
        hold_valid_reg <= 1'b1;
        hold_left_reg  <= s_left;
        hold_right_reg <= s_right;
      end else if (frame_start) begin
        hold_valid_reg <= 1'b0;
      end
    end
  end

  shift_register #(
    .WIDTH(SLOT_W)
  ) u_ser (
    .clk  (scki),
    .rst  (rst),
    .load (sr_load),
    .shift(sr_shift),
    .din  (sr_din),
    .msb  (adata)
  );

  assign bck      = bck_reg;
  assign lrck     = lrck_reg;
  assign underrun = underrun_reg;

endmodule

// File: doc/i2s_tx.md
I2S_TX -- requirements
Module: i2s_tx

Interface
REQ-001 Parameter DATA_W, default 24, sample width in bits; legal range 8..32.
REQ-002 Parameter SLOT_W, default 32, bck periods per channel slot; SLOT_W >= DATA_W+1, otherwise elaboration error.
REQ-003 Parameter BCK_DIV, default 4, scki cycles per bck period; even and >= 2, otherwise elaboration error.
REQ-004 scki  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 fmt  in  2  frame format: 00 I2S, 01 left-justified, 10 right-justified, 11 treated as I2S.
REQ-007 s_valid  in  1  sample pair offered.
REQ-008 s_ready  out  1  holding register empty; a transfer occurs when s_valid && s_ready.
REQ-009 s_left  in  DATA_W  left sample, two's complement.
REQ-010 s_right  in  DATA_W  right sample, two's complement.
REQ-011 bck  out  1  bit clock, registered.
REQ-012 lrck  out  1  word select: 0 = left slot, 1 = right slot, registered.
REQ-013 adata  out  1  serial data, MSB first, registered.
REQ-014 underrun  out  1  one-cycle pulse when a frame starts with the holding register empty.

Function
REQ-015 Divider counter runs 0..BCK_DIV-1 and wraps; bck = 0 for counts 0..BCK_DIV/2-1 and 1 for the rest.
REQ-016 lrck and adata change only on the cycle the divider wraps to 0 (bck falling edge), so they are stable at each bck rising edge.
REQ-017 Bit counter runs 0..2*SLOT_W-1 and advances on each divider wrap; one frame = 2*SLOT_W*BCK_DIV scki cycles.
REQ-018 Frame start is the divider wrap at which the bit counter becomes 0.
REQ-019 At frame start, fmt is latched, and the holding pair moves to the active pair, emptying the holding register.
REQ-020 If the holding register is empty at frame start, the active pair is all zeros and underrun pulses once.
REQ-021 Slot index k = bit counter mod SLOT_W; the slot word is s_left for bit counter < SLOT_W, else s_right.
REQ-022 Left-justified: k < DATA_W gives word[DATA_W-1-k]; otherwise 0.
REQ-023 Right-justified: k >= SLOT_W-DATA_W gives word[SLOT_W-1-k]; otherwise 0.
REQ-024 I2S: 1 <= k <= DATA_W gives word[DATA_W-k]; otherwise 0. lrck therefore leads the MSB by one bck period.
REQ-025 lrck = 0 for bit counter < SLOT_W and 1 otherwise, in all formats.
REQ-026 s_ready = holding register empty; a transfer fills it on the next edge.
REQ-027 When a transfer and frame start fall on the same cycle, the old holding contents move to the active pair and the new sample is stored in the holding register.
REQ-028 fmt changes mid-frame have no effect until the next frame start.
REQ-029 With s_valid held high, exactly one transfer occurs per frame.

Reset
REQ-030 While rst = 0 at an edge, the following take these values next cycle: counters 0; holding register empty; active pair 0; latched fmt 00; bck 0; lrck 1; adata 0; s_ready 1; underrun 0.
REQ-031 The first frame start occurs BCK_DIV scki cycles after the first edge with rst = 1.
REQ-032 Reset asserted mid-frame aborts the frame and discards held samples; no underrun pulse is produced for the aborted frame.

Structure
REQ-033 Package pcm_pkg holds the fmt encodings (FMT_I2S, FMT_LJ, FMT_RJ) and the parameter legality checks.
REQ-034 Serialisation uses the existing shift_register sub-module with WIDTH = SLOT_W, loaded with the pre-aligned slot word at each slot start and shifted once per divider wrap.

Verification
REQ-035 Use DATA_W=24, SLOT_W=32, BCK_DIV=4 (frame = 256 scki) for all scenarios below.
REQ-036 Left-justified, L=0xA5A5A5, R=0x5A5A5A -> left slot bits 0..23 = A5A5A5 MSB first, then 8 zeros with lrck=0; same pattern for R with lrck=1.
REQ-037 I2S, L=0x800001 -> left slot index 1 = 1, index 24 = 1, all others 0; lrck falls exactly one bck before the MSB.
REQ-038 Right-justified, R=0x000001 -> only right-slot index 31 = 1; adata is 0 across the whole left slot.
REQ-039 s_valid held 0 -> adata constant 0; underrun pulses once every 256 cycles; s_ready stays 1.
REQ-040 s_valid held 1 with incrementing data -> one transfer per 256 cycles, no underrun after the first frame, samples transmitted in order with none lost.
REQ-041 rst asserted at bit counter 40 -> next cycle all outputs at reset values; first frame start 4 cycles after release; the held sample is not transmitted.
